// File: rtl/pc_npc_sequencer_pkg.sv
// Shared types and defaults for the PC/nPC fetch sequencer.
// Holds the redirect state encoding and the reset/step constants.
package pc_npc_sequencer_pkg;

    localparam int          ADDR_W_DEFAULT      = 32;
    localparam int          INSTR_BYTES_DEFAULT = 4;
    localparam logic [31:0] RESET_PC_DEFAULT    = 32'h0000_0000;

    typedef enum logic [1:0] {
        SEQ  = 2'd0,
        PEND = 2'd1,
        SLOT = 2'd2
    } seq_state_t;

    // A redirect target is misaligned when either low byte-offset bit is set.
    function automatic logic target_misaligned(input logic [1:0] low_bits);
        return (low_bits != 2'b00);
    endfunction

endpackage

// File: rtl/pc_npc_sequencer_if.sv
// Redirect inputs from the branch-resolution chain and fetch-side outputs
// of the sequencer, bundled as one bus.
interface pc_npc_sequencer_if #(
    parameter int ADDR_W = pc_npc_sequencer_pkg::ADDR_W_DEFAULT
);
    logic              le;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_target;
    logic              annul;
    logic [ADDR_W-1:0] pc_out;
    logic [ADDR_W-1:0] npc_out;
    logic              fetch_valid;
    logic              slot_flag;
    logic              redirect_ack;
    logic              dslot_err;
    logic              align_err;

    modport master (
        output le, redirect_valid, redirect_target, annul,
        input  pc_out, npc_out, fetch_valid, slot_flag, redirect_ack, dslot_err, align_err
    );

    modport slave (
        input  le, redirect_valid, redirect_target, annul,
        output pc_out, npc_out, fetch_valid, slot_flag, redirect_ack, dslot_err, align_err
    );
endinterface

// File: rtl/pc_npc_sequencer.sv
// PC/nPC register pair with single-delay-slot redirect, optional slot annul
// and capture of redirects that arrive while the pipeline is stalled.
module pc_npc_sequencer
    import pc_npc_sequencer_pkg::*;
#(
    parameter int                ADDR_W      = ADDR_W_DEFAULT,
    parameter logic [ADDR_W-1:0] RESET_PC    = ADDR_W'(RESET_PC_DEFAULT),
    parameter int                INSTR_BYTES = INSTR_BYTES_DEFAULT
) (
    input  logic               clk,
    input  logic               reset_n,
    pc_npc_sequencer_if.slave  bus
);

    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(INSTR_BYTES);

    seq_state_t        state_r, state_s;
    logic              started_r, started_s;
    logic [ADDR_W-1:0] pc_r, pc_s;
    logic [ADDR_W-1:0] npc_r, npc_s;
    logic              fetch_valid_r, fetch_valid_s;
    logic              slot_flag_r, slot_flag_s;
    logic              redirect_ack_r, redirect_ack_s;
    logic              dslot_err_r, dslot_err_s;
    logic              align_err_r, align_err_s;
    logic [ADDR_W-1:0] pend_target_r, pend_target_s;
    logic              pend_annul_r, pend_annul_s;
    logic [ADDR_W-1:0] target_s;
    logic [ADDR_W-1:0] npc_inc_s;

    // Next-state and next-output computation for the redirect sequencer.
    always_comb begin
        state_s        = state_r;
        started_s      = started_r;
        pc_s           = pc_r;
        npc_s          = npc_r;
        fetch_valid_s  = fetch_valid_r;
        slot_flag_s    = slot_flag_r;
        redirect_ack_s = 1'b0;
        dslot_err_s    = dslot_err_r;
        align_err_s    = align_err_r;
        pend_target_s  = pend_target_r;
        pend_annul_s   = pend_annul_r;
        target_s       = {bus.redirect_target[ADDR_W-1:2], 2'b00};
        npc_inc_s      = npc_r + STEP;

        // The first edge out of reset only validates the fetch at RESET_PC.
        if (!started_r) begin
            started_s     = 1'b1;
            fetch_valid_s = 1'b1;
        end else begin
            case (state_r)
                SEQ: begin
                    if (bus.redirect_valid) begin
                        redirect_ack_s = 1'b1;
                        align_err_s    = align_err_r | target_misaligned(bus.redirect_target[1:0]);
                        if (bus.le) begin
                            pc_s          = npc_r;
                            npc_s         = target_s;
                            fetch_valid_s = ~bus.annul;
                            slot_flag_s   = 1'b1;
                            state_s       = SLOT;
                        end else begin
                            pend_target_s = target_s;
                            pend_annul_s  = bus.annul;
                            state_s       = PEND;
                        end
                    end else if (bus.le) begin
                        pc_s          = npc_r;
                        npc_s         = npc_inc_s;
                        fetch_valid_s = 1'b1;
                        slot_flag_s   = 1'b0;
                    end else begin
                        state_s = SEQ;
                    end
                end
                PEND: begin
                    // The captured redirect was acked on capture; new requests are ignored.
                    if (bus.le) begin
                        pc_s          = npc_r;
                        npc_s         = pend_target_r;
                        fetch_valid_s = ~pend_annul_r;
                        slot_flag_s   = 1'b1;
                        pend_annul_s  = 1'b0;
                        state_s       = SLOT;
                    end else begin
                        state_s = PEND;
                    end
                end
                SLOT: begin
                    if (bus.le) begin
                        pc_s          = npc_r;
                        npc_s         = npc_inc_s;
                        fetch_valid_s = 1'b1;
                        slot_flag_s   = 1'b0;
                        dslot_err_s   = dslot_err_r | bus.redirect_valid;
                        state_s       = SEQ;
                    end else begin
                        state_s = SLOT;
                    end
                end
                default: begin
                    state_s = SEQ;
                end
            endcase
        end
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r        <= SEQ;
            started_r      <= 1'b0;
            pc_r           <= RESET_PC;
            npc_r          <= RESET_PC + STEP;
            fetch_valid_r  <= 1'b0;
            slot_flag_r    <= 1'b0;
            redirect_ack_r <= 1'b0;
            dslot_err_r    <= 1'b0;
            align_err_r    <= 1'b0;
            pend_target_r  <= '0;
            pend_annul_r   <= 1'b0;
        end else begin
            state_r        <= state_s;
            started_r      <= started_s;
            pc_r           <= pc_s;
            npc_r          <= npc_s;
            fetch_valid_r  <= fetch_valid_s;
            slot_flag_r    <= slot_flag_s;
            redirect_ack_r <= redirect_ack_s;
            dslot_err_r    <= dslot_err_s;
            align_err_r    <= align_err_s;
            pend_target_r  <= pend_target_s;
            pend_annul_r   <= pend_annul_s;
        end
    end

    assign bus.pc_out       = pc_r;
    assign bus.npc_out      = npc_r;
    assign bus.fetch_valid  = fetch_valid_r;
    assign bus.slot_flag    = slot_flag_r;
    assign bus.redirect_ack = redirect_ack_r;
    assign bus.dslot_err    = dslot_err_r;
    assign bus.align_err    = align_err_r;

endmodule

// File: tb/tb_pc_npc_sequencer.sv
// Self-checking bench for pc_npc_sequencer: directed scenarios plus a
// randomized run, all compared against a behavioural fetch model.
module tb_pc_npc_sequencer;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    pc_npc_sequencer_if #(.ADDR_W(32)) bus ();

    pc_npc_sequencer dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Behavioural model: fetch addresses, flags and a queue of deferred redirects.
    logic [31:0] m_pc, m_npc;
    logic        m_fv, m_slot, m_ack, m_derr, m_aerr, m_started, m_in_slot;
    logic [32:0] pend_q[$];

    localparam logic [68:0] RESET_VEC = {32'h0, 32'h4, 5'b00000};

    function automatic logic [68:0] dut_vec();
        return {bus.pc_out, bus.npc_out, bus.fetch_valid, bus.slot_flag,
                bus.redirect_ack, bus.dslot_err, bus.align_err};
    endfunction

    function automatic logic [68:0] model_vec();
        return {m_pc, m_npc, m_fv, m_slot, m_ack, m_derr, m_aerr};
    endfunction

    task automatic model_reset();
        m_pc = 32'h0; m_npc = 32'h4;
        m_fv = 1'b0; m_slot = 1'b0; m_ack = 1'b0; m_derr = 1'b0; m_aerr = 1'b0;
        m_started = 1'b0; m_in_slot = 1'b0;
        pend_q.delete();
    endtask

    task automatic model_take(input logic [31:0] t, input logic a);
        m_pc = m_npc; m_npc = t; m_fv = !a; m_slot = 1'b1; m_in_slot = 1'b1;
    endtask

    task automatic model_edge(input logic le, input logic rv, input logic [31:0] tgt, input logic an);
        logic [32:0] r;
        m_ack = 1'b0;
        if (!m_started) begin
            m_started = 1'b1; m_fv = 1'b1;
        end else if (m_in_slot) begin
            if (le) begin
                if (rv) m_derr = 1'b1;
                m_pc = m_npc; m_npc = m_npc + 32'd4; m_slot = 1'b0; m_fv = 1'b1; m_in_slot = 1'b0;
            end
        end else if (pend_q.size() > 0) begin
            if (le) begin
                r = pend_q.pop_front();
                model_take(r[32:1], r[0]);
            end
        end else if (rv) begin
            m_ack = 1'b1;
            if (tgt % 32'd4 != 32'd0) m_aerr = 1'b1;
            if (le) model_take(tgt & ~32'd3, an);
            else pend_q.push_back({tgt & ~32'd3, an});
        end else if (le) begin
            m_pc = m_npc; m_npc = m_npc + 32'd4; m_fv = 1'b1; m_slot = 1'b0;
        end
    endtask

    task automatic cycle(input logic le, input logic rv, input logic [31:0] tgt, input logic an);
        bus.le = le; bus.redirect_valid = rv; bus.redirect_target = tgt; bus.annul = an;
        @(posedge clk);
        model_edge(le, rv, tgt, an);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        bus.le = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_target = 32'h0; bus.annul = 1'b0;
        model_reset();
        #12;
        total++;
        if (dut_vec() !== RESET_VEC) begin
            bad++; $display("FAIL reset: got %h want %h", dut_vec(), RESET_VEC);
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_free_run();
        logic [31:0] exp_pc;
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 1'b0, 32'h0, 1'b0);
            exp_pc = (i == 0) ? 32'h0 : 32'(4 * (i - 1));
            exp_pc = (i == 0) ? 32'h0 : exp_pc + 32'h4;
            total++;
            if (bus.pc_out !== exp_pc || bus.npc_out !== exp_pc + 32'h4 || bus.fetch_valid !== 1'b1) begin
                bad++; $display("FAIL free_run[%0d]: got pc=%h npc=%h fv=%b want pc=%h npc=%h fv=1",
                                i, bus.pc_out, bus.npc_out, bus.fetch_valid, exp_pc, exp_pc + 32'h4);
            end
            total++;
            if (dut_vec() !== model_vec()) begin
                bad++; $display("FAIL free_run_model[%0d]: got %h want %h", i, dut_vec(), model_vec());
            end
        end
    endtask

    task automatic test_redirect();
        cycle(1'b1, 1'b0, 32'h0, 1'b0);
        total++;
        if (bus.pc_out !== 32'h10) begin
            bad++; $display("FAIL redirect_pre: got pc=%h want 00000010", bus.pc_out);
        end
        cycle(1'b1, 1'b1, 32'h100, 1'b0);
        total++;
        if ({bus.pc_out, bus.npc_out, bus.slot_flag, bus.redirect_ack, bus.fetch_valid} !== {32'h14, 32'h100, 3'b111}) begin
            bad++; $display("FAIL redirect_slot: got pc=%h npc=%h slot=%b ack=%b fv=%b want 14/100/1/1/1",
                            bus.pc_out, bus.npc_out, bus.slot_flag, bus.redirect_ack, bus.fetch_valid);
        end
        cycle(1'b1, 1'b0, 32'h0, 1'b0);
        total++;
        if ({bus.pc_out, bus.npc_out, bus.slot_flag, bus.redirect_ack} !== {32'h100, 32'h104, 2'b00}) begin
            bad++; $display("FAIL redirect_target: got pc=%h npc=%h slot=%b ack=%b want 100/104/0/0",
                            bus.pc_out, bus.npc_out, bus.slot_flag, bus.redirect_ack);
        end
    endtask

    task automatic test_annul();
        logic [31:0] slot_pc;
        slot_pc = m_npc;
        cycle(1'b1, 1'b1, 32'h100, 1'b1);
        total++;
        if ({bus.pc_out, bus.fetch_valid, bus.slot_flag} !== {slot_pc, 2'b01}) begin
            bad++; $display("FAIL annul_slot: got pc=%h fv=%b slot=%b want %h/0/1",
                            bus.pc_out, bus.fetch_valid, bus.slot_flag, slot_pc);
        end
        cycle(1'b1, 1'b0, 32'h0, 1'b0);
        total++;
        if ({bus.pc_out, bus.fetch_valid, bus.slot_flag} !== {32'h100, 2'b10}) begin
            bad++; $display("FAIL annul_target: got pc=%h fv=%b slot=%b want 100/1/0",
                            bus.pc_out, bus.fetch_valid, bus.slot_flag);
        end
    endtask

    task automatic test_stall_redirect();
        logic [31:0] frozen_pc;
        int          acks;
        frozen_pc = bus.pc_out;
        acks = 0;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b1, 32'h200, 1'b0);
            if (bus.redirect_ack === 1'b1) acks++;
            total++;
            if (bus.pc_out !== frozen_pc || bus.redirect_ack !== (i == 0)) begin
                bad++; $display("FAIL stall[%0d]: got pc=%h ack=%b want pc=%h ack=%b",
                                i, bus.pc_out, bus.redirect_ack, frozen_pc, (i == 0));
            end
        end
        cycle(1'b1, 1'b1, 32'h200, 1'b0);
        if (bus.redirect_ack === 1'b1) acks++;
        total++;
        if ({bus.pc_out, bus.npc_out, bus.slot_flag} !== {frozen_pc + 32'h4, 32'h200, 1'b1}) begin
            bad++; $display("FAIL stall_slot: got pc=%h npc=%h slot=%b want %h/200/1",
                            bus.pc_out, bus.npc_out, bus.slot_flag, frozen_pc + 32'h4);
        end
        cycle(1'b1, 1'b0, 32'h0, 1'b0);
        total++;
        if (bus.pc_out !== 32'h200 || acks != 1) begin
            bad++; $display("FAIL stall_target: got pc=%h acks=%0d want 200/1", bus.pc_out, acks);
        end
    endtask

    task automatic test_dslot_err();
        cycle(1'b1, 1'b1, 32'h180, 1'b0);
        cycle(1'b1, 1'b1, 32'h300, 1'b0);
        total++;
        if ({bus.pc_out, bus.dslot_err, bus.redirect_ack} !== {32'h180, 2'b10}) begin
            bad++; $display("FAIL dslot: got pc=%h derr=%b ack=%b want 180/1/0",
                            bus.pc_out, bus.dslot_err, bus.redirect_ack);
        end
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 1'b0, 32'h0, 1'b0);
            total++;
            if (bus.pc_out === 32'h300 || bus.dslot_err !== 1'b1) begin
                bad++; $display("FAIL dslot_sticky[%0d]: got pc=%h derr=%b want pc!=300 derr=1",
                                i, bus.pc_out, bus.dslot_err);
            end
        end
    endtask

    task automatic test_wrap();
        cycle(1'b1, 1'b1, 32'hFFFF_FFF8, 1'b0);
        cycle(1'b1, 1'b0, 32'h0, 1'b0);
        cycle(1'b1, 1'b0, 32'h0, 1'b0);
        total++;
        if ({bus.pc_out, bus.npc_out} !== {32'hFFFF_FFFC, 32'h0}) begin
            bad++; $display("FAIL wrap: got pc=%h npc=%h want fffffffc/00000000", bus.pc_out, bus.npc_out);
        end
        cycle(1'b1, 1'b0, 32'h0, 1'b0);
        total++;
        if ({bus.pc_out, bus.npc_out} !== {32'h0, 32'h4}) begin
            bad++; $display("FAIL wrap_next: got pc=%h npc=%h want 0/4", bus.pc_out, bus.npc_out);
        end
    endtask

    task automatic test_align();
        cycle(1'b1, 1'b1, 32'h102, 1'b0);
        total++;
        if ({bus.npc_out, bus.align_err} !== {32'h100, 1'b1}) begin
            bad++; $display("FAIL align: got npc=%h aerr=%b want 100/1", bus.npc_out, bus.align_err);
        end
        cycle(1'b1, 1'b0, 32'h0, 1'b0);
        total++;
        if ({bus.pc_out, bus.align_err} !== {32'h100, 1'b1}) begin
            bad++; $display("FAIL align_target: got pc=%h aerr=%b want 100/1", bus.pc_out, bus.align_err);
        end
    endtask

    task automatic test_reset_mid_pend();
        cycle(1'b0, 1'b1, 32'h400, 1'b0);
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        total++;
        if (dut_vec() !== RESET_VEC) begin
            bad++; $display("FAIL reset_mid_pend: got %h want %h", dut_vec(), RESET_VEC);
        end
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0, 32'h0, 1'b0);
            total++;
            if (dut_vec() !== model_vec()) begin
                bad++; $display("FAIL post_reset[%0d]: got %h want %h", i, dut_vec(), model_vec());
            end
        end
    endtask

    task automatic test_random();
        logic        le, rv, an, prev_ack;
        logic [31:0] tgt;
        prev_ack = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            le  = ($urandom_range(9) < 7);
            rv  = ($urandom_range(9) < 3);
            an  = $urandom_range(1);
            tgt = $urandom();
            if ($urandom_range(3) != 0) tgt = tgt & ~32'd3;
            if (m_in_slot && !le) rv = 1'b0;
            cycle(le, rv, tgt, an);
            total++;
            if (dut_vec() !== model_vec()) begin
                bad++; $display("FAIL random[%0d]: got %h want %h", i, dut_vec(), model_vec());
            end
            total++;
            if (prev_ack && bus.redirect_ack) begin
                bad++; $display("FAIL ack_pulse[%0d]: got ack=1 twice want single pulse", i);
            end
            prev_ack = bus.redirect_ack;
        end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_redirect();
        test_annul();
        test_stall_redirect();
        test_dslot_err();
        test_wrap();
        test_align();
        test_reset_mid_pend();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
